risc_controller: RTL

Control FSM and instruction decoder for the Simple RISC Machine, driving the datapath's control inputs (load enables, muxes, register numbers, ALU/shift ops, immediates). It latches a 16-bit instruction on a start strobe and sequences it through a fixed multi-cycle state machine. It signals completion by reasserting `w`. All datapath control signals originate here, with a one-to-one mapping onto the datapath port list.

---
 rtl/risc_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/risc_controller.sv
// Control FSM and instruction decoder for the Simple RISC Machine.
// Latches an instruction on start and sequences the datapath's control inputs.
module risc_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s,
   input  logic [15:0] in,
   output logic        w,
   output logic        illegal,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        write,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [1:0]  vsel,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_ALU,
      S_CMP,
      S_WRITE_REG
   } state_e;

   typedef enum logic [1:0] {
      NSEL_RN,
      NSEL_RD,
      NSEL_RM
   } nsel_e;

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   nsel_e       nsel;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn, rd, rm;
   logic [1:0] sh;
   logic       is_movimm, is_movreg, is_alu, is_cmp, is_mvn, is_legal;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign sh     = ir_q[4:3];
   assign rm     = ir_q[2:0];

   assign is_movimm = (opcode == 3'b110) && (op == 2'b10);
   assign is_movreg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu    = (opcode == 3'b101);
   assign is_cmp    = is_alu && (op == 2'b01);
   assign is_mvn    = is_alu && (op == 2'b11);
   assign is_legal  = is_movimm || is_movreg || is_alu;

   assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
   assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_WAIT;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      nsel     = NSEL_RN;
      w        = 1'b0;
      illegal  = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      write    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      vsel     = 2'b00;
      case (state_q)
         S_WAIT: begin
            w = 1'b1;
            if (s) begin
               ir_d    = in;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_movimm)                state_d = S_WRITE_IMM;
            else if (is_movreg || is_mvn) state_d = S_GET_B;
            else if (is_alu)              state_d = S_GET_A;
            else begin
               illegal = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WRITE_IMM: begin
            nsel    = NSEL_RN;
            vsel    = 2'b10;
            write   = 1'b1;
            state_d = S_WAIT;
         end
         S_GET_A: begin
            nsel    = NSEL_RN;
            loada   = 1'b1;
            state_d = S_GET_B;
         end
         S_GET_B: begin
            nsel    = NSEL_RM;
            loadb   = 1'b1;
            state_d = is_cmp ? S_CMP : S_ALU;
         end
         S_ALU: begin
            shift   = sh;
            loadc   = 1'b1;
            // MOV reg passes B through the adder with a zero A operand
            asel    = is_movreg;
            ALUop   = is_movreg ? 2'b00 : op;
            state_d = S_WRITE_REG;
         end
         S_CMP: begin
            shift   = sh;
            ALUop   = 2'b01;
            loads   = 1'b1;
            state_d = S_WAIT;
         end
         S_WRITE_REG: begin
            nsel    = NSEL_RD;
            vsel    = 2'b00;
            write   = 1'b1;
            state_d = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_comb begin
      case (nsel)
         NSEL_RD: readnum = rd;
         NSEL_RM: readnum = rm;
         default: readnum = rn;
      endcase
   end

   assign writenum = readnum;

endmodule
